// File: rtl/clock_set_ctrl.sv
// Mode/time-set controller and BCD timekeeping datapath for the digital clock.
// Holds hh:mm:ss in BCD, sequences RUN/SET_HOUR/SET_MIN, drives blink and chime.
module clock_set_ctrl #(
    parameter int unsigned BLINK_CYC = 12_500_000,
    parameter logic [7:0]  INIT_HOUR = 8'h00,
    parameter logic [7:0]  INIT_MIN  = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic [1:0] mode,
    output logic       blink_h,
    output logic       blink_m,
    output logic       chime_en,
    output logic       time_set
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_t;

    localparam int unsigned CW = (BLINK_CYC > 2) ? $clog2(BLINK_CYC) : 1;
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CYC - 1);

    mode_t         state, state_n;
    logic [7:0]    hour_n, minute_n, second_n;
    logic [CW-1:0] blink_cnt, blink_cnt_n;
    logic          phase, phase_n;
    logic          time_set_n;
    logic          restart;
    logic          sec_wrap, min_wrap;

    // Modulo BCD increment: top wraps to 00, units 9 carries into tens.
    function automatic logic [7:0] bcd_inc(
        input logic [7:0] v,
        input logic [7:0] top
    );
        logic [7:0] r;
        if (v == top) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    assign sec_wrap = (second == 8'h59);
    assign min_wrap = (minute == 8'h59);

    // Next-state: mode sequencing, time update, field adjust, blink timing.
    always_comb begin
        state_n     = state;
        hour_n      = hour;
        minute_n    = minute;
        second_n    = second;
        blink_cnt_n = blink_cnt;
        phase_n     = phase;
        time_set_n  = 1'b0;
        restart     = 1'b0;

        if (state == RUN && tick_1hz) begin
            second_n = bcd_inc(second, 8'h59);
            if (sec_wrap) begin
                minute_n = bcd_inc(minute, 8'h59);
                if (min_wrap) begin
                    hour_n = bcd_inc(hour, 8'h23);
                end
            end
        end

        if (btn_mode) begin
            restart = 1'b1;
            unique case (state)
                RUN:      state_n = SET_HOUR;
                SET_HOUR: state_n = SET_MIN;
                SET_MIN: begin
                    state_n    = RUN;
                    second_n   = 8'h00;
                    time_set_n = 1'b1;
                end
                default:  state_n = RUN;
            endcase
        end else if (btn_inc) begin
            unique case (state)
                SET_HOUR: begin
                    hour_n  = bcd_inc(hour, 8'h23);
                    restart = 1'b1;
                end
                SET_MIN: begin
                    minute_n = bcd_inc(minute, 8'h59);
                    restart  = 1'b1;
                end
                default: ;
            endcase
        end

        if (restart || state == RUN) begin
            blink_cnt_n = '0;
            phase_n     = 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_n = '0;
            phase_n     = ~phase;
        end else begin
            blink_cnt_n = blink_cnt + 1'b1;
        end
    end

    // State and registered outputs; reset overrides every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            hour      <= INIT_HOUR;
            minute    <= INIT_MIN;
            second    <= 8'h00;
            blink_cnt <= '0;
            phase     <= 1'b0;
            blink_h   <= 1'b0;
            blink_m   <= 1'b0;
            chime_en  <= 1'b1;
            time_set  <= 1'b0;
        end else begin
            state     <= state_n;
            hour      <= hour_n;
            minute    <= minute_n;
            second    <= second_n;
            blink_cnt <= blink_cnt_n;
            phase     <= phase_n;
            blink_h   <= (state_n == SET_HOUR) && phase_n;
            blink_m   <= (state_n == SET_MIN) && phase_n;
            chime_en  <= (state_n == RUN);
            time_set  <= time_set_n;
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: decimal reference model predicts
// every output cycle; expectations queued at drive, checked after the edge.
module tb_clock_set_ctrl;

    localparam int BC = 4;
    localparam int IH = 12;
    localparam int IM = 34;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [7:0] hour, minute, second;
    logic [1:0] mode;
    logic       blink_h, blink_m, chime_en, time_set;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic [1:0] md;
        logic       bh;
        logic       bm;
        logic       ce;
        logic       ts;
    } exp_t;

    exp_t sb[$];

    int mh, mm, ms, md, cnt, ph, ts;

    clock_set_ctrl #(
        .BLINK_CYC(BC),
        .INIT_HOUR(8'h12),
        .INIT_MIN (8'h34)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_1hz(tick_1hz),
        .btn_mode(btn_mode),
        .btn_inc (btn_inc),
        .hour    (hour),
        .minute  (minute),
        .second  (second),
        .mode    (mode),
        .blink_h (blink_h),
        .blink_m (blink_m),
        .chime_en(chime_en),
        .time_set(time_set)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: sim time exceeded, got running required done");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic advance();
        ms++;
        if (ms == 60) begin
            ms = 0;
            mm++;
            if (mm == 60) begin
                mm = 0;
                mh = (mh + 1) % 24;
            end
        end
    endtask

    task automatic model(input logic r, input logic t,
                         input logic m, input logic i);
        int chg;
        if (r) begin
            mh = IH; mm = IM; ms = 0; md = 0;
            cnt = 0; ph = 0; ts = 0;
        end else begin
            ts = 0;
            chg = 0;
            if (m) begin
                if (md == 0 && t) advance();
                md = (md == 2) ? 0 : md + 1;
                if (md == 0) begin
                    ms = 0;
                    ts = 1;
                end
                chg = 1;
            end else if (md == 0) begin
                if (t) advance();
            end else if (i) begin
                if (md == 1) mh = (mh + 1) % 24;
                else mm = (mm + 1) % 60;
                chg = 1;
            end
            if (chg != 0 || md == 0) begin
                cnt = 0;
                ph = 0;
            end else if (cnt == BC - 1) begin
                cnt = 0;
                ph = 1 - ph;
            end else begin
                cnt++;
            end
        end
    endtask

    task automatic step(input logic r, input logic t,
                        input logic m, input logic i);
        exp_t e;
        rst = r; tick_1hz = t; btn_mode = m; btn_inc = i;
        model(r, t, m, i);
        e.h  = bcd(mh);
        e.m  = bcd(mm);
        e.s  = bcd(ms);
        e.md = 2'(md);
        e.bh = (md == 1) && (ph == 1);
        e.bm = (md == 2) && (ph == 1);
        e.ce = (md == 0);
        e.ts = (ts == 1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("hour",     32'(hour),     32'(e.h));
            check("minute",   32'(minute),   32'(e.m));
            check("second",   32'(second),   32'(e.s));
            check("mode",     32'(mode),     32'(e.md));
            check("blink_h",  32'(blink_h),  32'(e.bh));
            check("blink_m",  32'(blink_m),  32'(e.bm));
            check("chime_en", 32'(chime_en), 32'(e.ce));
            check("time_set", 32'(time_set), 32'(e.ts));
        end
    endtask

    initial begin
        mh = 0; mm = 0; ms = 0; md = 0; cnt = 0; ph = 0; ts = 0;
        #1;
        // reset, including with all event inputs high
        step(1, 0, 0, 0);
        step(1, 1, 1, 1);
        check("rst_hour", 32'(hour), 32'h12);
        check("rst_min",  32'(minute), 32'h34);
        check("rst_mode", 32'(mode), 32'd0);

        // 1: preload 23:59 via set, run to 23:59:58, then roll over
        step(0, 0, 1, 0);
        for (int k = 0; k < 11; k++) step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        for (int k = 0; k < 25; k++) step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        for (int k = 0; k < 58; k++) step(0, 1, 0, 0);
        check("t1_pre", 32'({hour, minute, second}), 32'h235958);
        step(0, 1, 0, 0);
        check("t1_59", 32'({hour, minute, second}), 32'h235959);
        step(0, 1, 0, 0);
        check("t1_wrap", 32'({hour, minute, second}), 32'h000000);
        check("t1_mode", 32'(mode), 32'd0);

        // btn_inc in RUN is ignored; accumulate some seconds
        for (int k = 0; k < 5; k++) step(0, 1, 0, 1);

        // 2: set hour with ticks present; hour wraps past 23
        step(0, 0, 1, 0);
        for (int k = 0; k < 25; k++) step(0, 1, 0, 1);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0);
        check("t2_hour", 32'(hour), 32'h01);
        check("t2_sec", 32'(second), 32'h05);

        // 3: minute 59->00 without hour carry; exit clears seconds
        step(0, 0, 1, 0);
        for (int k = 0; k < 59; k++) step(0, 1, 0, 1);
        check("t3_m59", 32'(minute), 32'h59);
        step(0, 0, 0, 1);
        check("t3_m00", 32'(minute), 32'h00);
        check("t3_hour", 32'(hour), 32'h01);
        step(0, 0, 1, 0);
        check("t3_ts", 32'(time_set), 32'd1);
        check("t3_sec", 32'(second), 32'h00);
        check("t3_chime", 32'(chime_en), 32'd1);
        step(0, 0, 0, 0);
        check("t3_ts_off", 32'(time_set), 32'd0);

        // 4: blink in SET_HOUR, restart on increment
        step(0, 0, 1, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0);
        check("t4_bh_on", 32'(blink_h), 32'd1);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        check("t4_bh_rst", 32'(blink_h), 32'd0);
        for (int k = 0; k < 9; k++) step(0, 0, 0, 0);
        check("t4_bm", 32'(blink_m), 32'd0);

        // 5: mode+inc together drops inc; RUN mode+tick does both
        step(0, 0, 1, 1);
        check("t5_mode", 32'(mode), 32'd2);
        check("t5_hour", 32'(hour), 32'h02);
        step(0, 0, 1, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        check("t5_sec", 32'(second), 32'h04);
        check("t5_mode1", 32'(mode), 32'd1);

        // 6: reset mid-blink in SET_MIN
        step(0, 0, 1, 0);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 0);
        step(1, 1, 1, 1);
        check("t6_mode", 32'(mode), 32'd0);
        check("t6_time", 32'({hour, minute, second}), 32'h123400);

        // random soak against the model
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
